fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives the instruction-memory request port, and presents `instr_f` / `pc_plus_4_f` to the F/D pipeline register directly downstream. It absorbs variable imem latency, hazard-unit stalls and branch/jump redirects from decode. When no valid instruction is available it presents a NOP bubble.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Used by the fetch stage and by any downstream stage that needs NOP or reset defaults.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests and presents instr_f / pc_plus_4_f.
// Absorbs imem wait states, hazard stalls and decode redirects; emits NOP bubbles otherwise.
//
// state | meaning
// FETCH | request outstanding for pc_q
// HOLD  | fetched word buffered in buf_q while stall_f is high
// KILL  | squashed request to kill_addr_q still outstanding, its data is discarded
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus_4_f,
  output logic        fetch_busy
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  kill_addr_q, kill_addr_d;
  logic [31:0]  redirect_tgt;
  logic         req_int;
  logic         deliver;
  logic [31:0]  instr_int;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_q       <= NOP_INSTR;
      kill_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      kill_addr_q <= kill_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    kill_addr_d = kill_addr_q;
    req_int     = 1'b0;
    imem_addr   = pc_q;
    deliver     = 1'b0;
    instr_int   = NOP_INSTR;
    case (state_q)
      FETCH: begin
        req_int = 1'b1;
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // The in-flight request cannot be withdrawn, so wait out its completion.
          if (!imem_ready) begin
            kill_addr_d = pc_q;
            state_d     = KILL;
          end
        end else if (imem_ready) begin
          deliver   = 1'b1;
          instr_int = imem_rdata;
          if (stall_f) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            pc_d = pc_next(pc_q);
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else begin
          deliver   = 1'b1;
          instr_int = buf_q;
          if (!stall_f) begin
            pc_d    = pc_next(pc_q);
            state_d = FETCH;
          end
        end
      end
      KILL: begin
        req_int   = 1'b1;
        imem_addr = kill_addr_q;
        if (redirect_valid) pc_d = redirect_tgt;
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_req    = req_int & rst;
  assign instr_f     = (deliver && rst) ? instr_int : NOP_INSTR;
  assign fetch_busy  = ~(deliver & rst);
  assign pc_f        = pc_q;
  assign pc_plus_4_f = pc_next(pc_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle stimulus with a scoreboard of expected deliveries.
// The memory model answers every address with addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_f = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus_4_f;
  logic        fetch_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q[$];

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_f(instr_f), .pc_f(pc_f), .pc_plus_4_f(pc_plus_4_f),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at negedge, then advance past the next posedge.
  task automatic cyc(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc,
                     input logic exp_req, input logic [31:0] exp_addr,
                     input logic exp_dlv, input logic [31:0] exp_pc);
    logic [31:0] exp_p4;
    logic [31:0] sb_pc;
    imem_ready     = rdy;
    stall_f        = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    exp_p4 = exp_pc + 32'd4;
    if (exp_dlv) sb_q.push_back(exp_pc);
    @(negedge clk);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, ~exp_dlv});
    chk("pc_f", pc_f, exp_pc);
    chk("pc_plus_4_f", pc_plus_4_f, exp_p4);
    if (!fetch_busy) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_delivery", instr_f, 32'hDEAD_BEEF);
      end else begin
        sb_pc = sb_q.pop_front();
        chk("sb_instr", instr_f, sb_pc ^ KEY);
        chk("sb_pc", pc_f, sb_pc);
      end
    end else begin
      chk("bubble_nop", instr_f, 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_f, 32'h0);
    chk("rst_pc", pc_f, 32'h0);
    chk("rst_pc4", pc_plus_4_f, 32'h4);
    chk("rst_busy", {31'b0, fetch_busy}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int a = 0; a < 16; a += 4) cyc(1, 0, 0, 0, 1, 32'(a), 1, 32'(a));

    cyc(0, 0, 0, 0, 1, 32'h10, 0, 32'h10);
    cyc(0, 0, 0, 0, 1, 32'h10, 0, 32'h10);
    for (int a = 'h10; a < 'h20; a += 4) cyc(1, 0, 0, 0, 1, 32'(a), 1, 32'(a));

    cyc(1, 1, 0, 0, 1, 32'h20, 1, 32'h20);
    cyc(0, 1, 0, 0, 0, 32'h0, 1, 32'h20);
    cyc(0, 1, 0, 0, 0, 32'h0, 1, 32'h20);
    cyc(0, 0, 0, 0, 0, 32'h0, 1, 32'h20);
    for (int a = 'h24; a < 'h40; a += 4) cyc(1, 0, 0, 0, 1, 32'(a), 1, 32'(a));

    cyc(0, 0, 1, 32'h103, 1, 32'h40, 0, 32'h40);
    cyc(0, 0, 0, 0, 1, 32'h40, 0, 32'h100);
    cyc(1, 0, 0, 0, 1, 32'h40, 0, 32'h100);
    cyc(1, 0, 0, 0, 1, 32'h100, 1, 32'h100);

    cyc(1, 1, 1, 32'h200, 1, 32'h104, 0, 32'h104);
    cyc(1, 0, 0, 0, 1, 32'h200, 1, 32'h200);

    cyc(1, 1, 0, 0, 1, 32'h204, 1, 32'h204);
    cyc(0, 1, 1, 32'h302, 0, 32'h0, 0, 32'h204);
    cyc(1, 0, 0, 0, 1, 32'h300, 1, 32'h300);

    cyc(1, 0, 1, 32'hFFFF_FFFF, 1, 32'h304, 0, 32'h304);
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 1, 32'h0, 1, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h4, 0, 32'h4);

    imem_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_pc", pc_f, 32'h0);
    chk("arst_busy", {31'b0, fetch_busy}, 32'h1);
    chk("arst_instr", instr_f, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1, 0, 0, 0, 1, 32'h0, 1, 32'h0);
    cyc(1, 0, 0, 0, 1, 32'h4, 1, 32'h4);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
